// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that serialises requester words into
// a byte stream for a UART transmitter, MSB byte first, one frame per grant.
// Ports: clk, s_reset (sync, active-high); req_valid/req_data/req_ready per
// requester; tx_valid/tx_data/tx_ready toward the UART; busy, grant_id,
// frame_done status.
// Optional macro UART_ARB_HEADER_EN prefixes each frame with the header
// byte {4'hA, 1'b0, grant_id}.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          s_reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    input  logic                          tx_ready,
    output logic                          busy,
    output logic [2:0]                    grant_id,
    output logic                          frame_done
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              rr_q, rr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [2:0]              gid_q, gid_d;

    logic                    gnt_found;
    logic [2:0]              gnt_idx;
    logic [DATA_WIDTH-1:0]   gnt_word;
    logic [3:0]              cand;
    logic                    xfer;

    assign busy     = (state_q != IDLE);
    assign tx_valid = busy;
    assign grant_id = gid_q;
    assign xfer     = tx_valid & tx_ready;

    // Round-robin search: candidate k positions above rr_q, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_word  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + 4'(k);
            if (cand >= 4'(NUM_REQ))
                cand = cand - 4'(NUM_REQ);
            for (int p = 0; p < NUM_REQ; p++) begin
                if (!gnt_found && req_valid[p] && cand == 4'(p)) begin
                    gnt_found = 1'b1;
                    gnt_idx   = 3'(p);
                    gnt_word  = req_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        gid_d      = gid_q;
        req_ready  = '0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt_found && !s_reset) begin
                    for (int p = 0; p < NUM_REQ; p++)
                        req_ready[p] = (gnt_idx == 3'(p));
                    data_d = gnt_word;
                    gid_d  = gnt_idx;
                    cnt_d  = '0;
`ifdef UART_ARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = DATA;
`endif
                end
            end
            HDR: begin
                if (xfer)
                    state_d = DATA;
            end
            DATA: begin
                if (xfer) begin
                    if (cnt_q == LAST) begin
                        frame_done = !s_reset;
                        cnt_d      = '0;
                        state_d    = IDLE;
                        rr_d = (gid_q == 3'(NUM_REQ - 1)) ?
                               3'd0 : gid_q + 3'd1;
                    end else begin
                        cnt_d  = cnt_q + CW'(1);
                        data_d = data_q << 8;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data bytes come from the top of a left-shifting word register.
    always_comb begin
        tx_data = 8'h00;
        unique case (state_q)
            IDLE:    tx_data = 8'h00;
            HDR:     tx_data = {4'hA, 1'b0, gid_q};
            DATA:    tx_data = data_q[DATA_WIDTH-1 -: 8];
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
        end
    end

endmodule
